// File: rtl/l1_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// Ram_if
//
// Purpose:
//   Single-port memory access bundle shared by the L1 arbiter, its two
//   requesters and the L1 data memory behind it. One access per cycle,
//   read data returned one cycle after the accepting cycle, stall via delay.
//
// Signals:
//   en      access request / strobe
//   we      1 = write, 0 = read
//   be      byte enables, one bit per 8-bit lane (DATA_WIDTH/8 bits)
//   addr    word address
//   data_w  write data
//   data_r  read data (registered, valid the cycle after a completed read)
//   delay   stall: the access presented this cycle is not accepted
//
// Modports:
//   memory  the side that serves accesses (en..data_w in, data_r/delay out)
//   client  the side that issues accesses (en..data_w out, data_r/delay in)
// -----------------------------------------------------------------------------
interface Ram_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                    en;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data_w;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    delay;

    modport memory (
        input  en,
        input  we,
        input  be,
        input  addr,
        input  data_w,
        output data_r,
        output delay
    );

    modport client (
        output en,
        output we,
        output be,
        output addr,
        output data_w,
        input  data_r,
        input  delay
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// l1_mem_arbiter
//
// Purpose:
//   Shares one single-port L1 data memory between two requesters. Each cycle
//   at most one access is forwarded to the memory; a requester that loses the
//   grant, or whose granted access is stalled by the memory, sees delay=1 and
//   must hold its access. Read data from the memory is steered back to the
//   requester that issued the read, and each requester's data_r stays stable
//   until its next read returns.
//
// Parameters:
//   ADDR_WIDTH  word address width (matches the memory)
//   DATA_WIDTH  data width, multiple of 8
//   FIXED_PRIO  0: round-robin on contention, 1: port 0 always wins
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-low reset
//   req0, req1    requester ports (Ram_if.memory)
//   mem           port to the L1 memory (Ram_if.client)
//   conflict_cnt  saturating count of cycles with both requesters active
// -----------------------------------------------------------------------------
module l1_mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    Ram_if.memory       req0,
    Ram_if.memory       req1,
    Ram_if.client       mem,
    output logic [15:0] conflict_cnt
);

    // Saturating increment for the contention counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic                  both;
    logic                  any_req;
    logic                  win;        // 0: port 0 granted, 1: port 1 granted
    logic                  last_win;   // winner of the last accepted contested cycle
    logic                  delay0;
    logic                  delay1;
    logic                  done0;
    logic                  done1;
    logic [1:0]            rsel;
    logic [1:0]            rsel_nxt;
    logic [DATA_WIDTH-1:0] hold0;
    logic [DATA_WIDTH-1:0] hold1;

    // ---- request cycle: grant decision and forwarding ----------------------
    always_comb begin
        both    = req0.en & req1.en;
        any_req = reset & (req0.en | req1.en);
        if (both) begin
            // Round-robin hands the contested cycle to whoever lost last time.
            win = FIXED_PRIO ? 1'b0 : ~last_win;
        end else begin
            win = ~req0.en;
        end
    end

    always_comb begin
        mem.en     = any_req;
        mem.we     = 1'b0;
        mem.be     = '0;
        mem.addr   = '0;
        mem.data_w = '0;
        if (any_req) begin
            if (win) begin
                mem.we     = req1.we;
                mem.be     = req1.be;
                mem.addr   = req1.addr;
                mem.data_w = req1.data_w;
            end else begin
                mem.we     = req0.we;
                mem.be     = req0.be;
                mem.addr   = req0.addr;
                mem.data_w = req0.data_w;
            end
        end
    end

    // Stall depends only on requests, the grant and the memory stall, never on
    // returning read data.
    assign delay0     = reset & req0.en & (win | mem.delay);
    assign delay1     = reset & req1.en & (~win | mem.delay);
    assign req0.delay = delay0;
    assign req1.delay = delay1;

    assign done0    = req0.en & ~delay0;
    assign done1    = req1.en & ~delay1;
    assign rsel_nxt = {done1 & ~req1.we, done0 & ~req0.we};

    // ---- return cycle: steer registered memory data to the reader ---------
    // The reader sees the memory output directly in the return cycle and its
    // private hold register afterwards, so data_r never glitches to another
    // port's read data.
    assign req0.data_r = rsel[0] ? mem.data_r : hold0;
    assign req1.data_r = rsel[1] ? mem.data_r : hold1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_win     <= 1'b1;
            rsel         <= 2'b00;
            hold0        <= '0;
            hold1        <= '0;
            conflict_cnt <= 16'd0;
        end else begin
            // A contested cycle stalled by the memory is replayed with the
            // same winner, so fairness only advances on accepted accesses.
            if (both && !mem.delay) begin
                last_win <= win;
            end
            rsel <= rsel_nxt;
            if (rsel[0]) begin
                hold0 <= mem.data_r;
            end
            if (rsel[1]) begin
                hold1 <= mem.data_r;
            end
            if (both) begin
                conflict_cnt <= sat_inc(conflict_cnt);
            end
        end
    end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_l1_mem_arbiter
//
// Bench for l1_mem_arbiter: a behavioural single-port memory sits behind the
// round-robin instance; a second instance with FIXED_PRIO=1 is driven
// separately. A reference model tracks expected grants, stalls, read data and
// contention count from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_l1_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    Ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r0 ();
    Ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) r1 ();
    Ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m ();
    Ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f0 ();
    Ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f1 ();
    Ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fm ();

    logic [15:0] cnt;
    logic [15:0] fcnt;

    l1_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset), .req0(r0), .req1(r1), .mem(m), .conflict_cnt(cnt)
    );

    l1_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .reset(reset), .req0(f0), .req1(f1), .mem(fm), .conflict_cnt(fcnt)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Behavioural L1 memory: one access per accepted cycle, registered read.
    logic [31:0] mem_arr [0:1023];
    logic        mem_clear;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'd0;
        end else if (m.en && !m.delay) begin
            if (m.we) mem_arr[m.addr] <= merge(mem_arr[m.addr], m.data_w, m.be);
            else      m.data_r <= mem_arr[m.addr];
        end
    end

    // Reference model state.
    int          m_last;
    int          m_cnt;
    logic [31:0] m_rd [2];
    logic        m_stall [2];
    logic [31:0] m_mem [0:1023];

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 1;
        m_cnt = 0;
        m_rd[0] = 32'd0;
        m_rd[1] = 32'd0;
        m_stall[0] = 1'b0;
        m_stall[1] = 1'b0;
    endtask

    task automatic drive(input int p, input logic en, input logic we, input logic [3:0] be,
                         input logic [9:0] addr, input logic [31:0] d);
        if (p == 0) begin
            r0.en = en; r0.we = we; r0.be = be; r0.addr = addr; r0.data_w = d;
        end else begin
            r1.en = en; r1.we = we; r1.be = be; r1.addr = addr; r1.data_w = d;
        end
    endtask

    // One clock cycle with the currently driven requests, checked against the
    // model at the falling edge; returns 1 time unit after the next rising edge.
    task automatic cycle(input logic mdel);
        logic        e0, e1, both, exp_d0, exp_d1;
        int          win;
        logic        w_we;
        logic [3:0]  w_be;
        logic [9:0]  w_addr;
        logic [31:0] w_d;
        m.delay = mdel;
        @(negedge clk);
        e0 = r0.en;
        e1 = r1.en;
        both = e0 && e1;
        if (both)    win = 1 - m_last;
        else if (e0) win = 0;
        else         win = 1;
        exp_d0 = e0 && ((win != 0) || mdel);
        exp_d1 = e1 && ((win != 1) || mdel);
        w_we   = (win == 0) ? r0.we : r1.we;
        w_be   = (win == 0) ? r0.be : r1.be;
        w_addr = (win == 0) ? r0.addr : r1.addr;
        w_d    = (win == 0) ? r0.data_w : r1.data_w;
        chk("delay0", r0.delay, exp_d0);
        chk("delay1", r1.delay, exp_d1);
        chk("data_r0", r0.data_r, m_rd[0]);
        chk("data_r1", r1.data_r, m_rd[1]);
        chk("conflict_cnt", cnt, m_cnt);
        chk("mem_en", m.en, e0 || e1);
        if (e0 || e1) begin
            chk("mem_addr", m.addr, w_addr);
            chk("mem_we", m.we, w_we);
        end
        m_stall[0] = exp_d0;
        m_stall[1] = exp_d1;
        if (both && !mdel) m_last = win;
        if (both && m_cnt < 65535) m_cnt++;
        if ((e0 || e1) && !mdel) begin
            if (w_we) m_mem[w_addr] = merge(m_mem[w_addr], w_d, w_be);
            else      m_rd[win] = m_mem[w_addr];
        end
        @(posedge clk);
        #1;
    endtask

    int comp0, comp1;

    initial begin
        mem_clear = 1'b1;
        m.delay = 1'b0;
        fm.delay = 1'b0;
        fm.data_r = 32'd0;
        f0.en = 0; f0.we = 0; f0.be = 4'hF; f0.addr = 10'd3; f0.data_w = 0;
        f1.en = 0; f1.we = 0; f1.be = 4'hF; f1.addr = 10'd4; f1.data_w = 0;
        model_reset();
        for (int i = 0; i < 1024; i++) m_mem[i] = 32'd0;

        // Reset holds outputs quiet even with both ports requesting.
        drive(0, 1, 0, 4'hF, 10'd1, 0);
        drive(1, 1, 0, 4'hF, 10'd2, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_en", m.en, 0);
        chk("rst_delay0", r0.delay, 0);
        chk("rst_delay1", r1.delay, 0);
        chk("rst_data_r0", r0.data_r, 0);
        chk("rst_data_r1", r1.data_r, 0);
        chk("rst_cnt", cnt, 0);
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        drive(1, 0, 0, 4'h0, 10'd0, 0);
        mem_clear = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single port write then read.
        drive(0, 1, 1, 4'hF, 10'd5, 32'hDEADBEEF); cycle(0);
        drive(0, 1, 0, 4'hF, 10'd5, 0);            cycle(0);
        chk("single_rd", r0.data_r, 32'hDEADBEEF);
        // Preload words used by later steps.
        drive(0, 1, 1, 4'hF, 10'd1, 32'h11); cycle(0);
        drive(0, 1, 1, 4'hF, 10'd2, 32'h22); cycle(0);
        drive(0, 1, 1, 4'hF, 10'd9, 32'h0);  cycle(0);
        drive(0, 0, 0, 4'h0, 10'd0, 0);      cycle(0);

        // First contention after reset.
        drive(0, 1, 0, 4'hF, 10'd1, 0);
        drive(1, 1, 0, 4'hF, 10'd2, 0);
        #1;
        chk("ct0_delay0", r0.delay, 0);
        chk("ct0_delay1", r1.delay, 1);
        cycle(0);
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        #1;
        chk("ct1_delay1", r1.delay, 0);
        chk("ct1_data_r0", r0.data_r, 32'h11);
        chk("ct1_cnt", cnt, 1);
        cycle(0);
        drive(1, 0, 0, 4'h0, 10'd0, 0);
        chk("ct2_data_r1", r1.data_r, 32'h22);
        chk("ct2_data_r0", r0.data_r, 32'h11);
        cycle(0);

        // Sustained contention, round-robin.
        comp0 = 0;
        comp1 = 0;
        drive(0, 1, 0, 4'hF, 10'd1, 0);
        drive(1, 1, 0, 4'hF, 10'd2, 0);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (!r0.delay) comp0++;
            if (!r1.delay) comp1++;
            cycle(0);
        end
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        drive(1, 0, 0, 4'h0, 10'd0, 0);
        chk("rr_comp0", comp0, 5);
        chk("rr_comp1", comp1, 5);
        chk("rr_cnt", cnt, 11);
        cycle(0);

        // Byte enables: port 1 partial write, port 0 reads back.
        drive(1, 1, 1, 4'b0101, 10'd9, 32'hAABBCCDD); cycle(0);
        drive(1, 0, 0, 4'h0, 10'd0, 0);
        drive(0, 1, 0, 4'hF, 10'd9, 0);               cycle(0);
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        chk("be_rd", r0.data_r, 32'h00BB00DD);
        cycle(0);

        // Randomised traffic with memory stalls; stalled accesses are held.
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!m_stall[p])
                    drive(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 15)), 10'($urandom_range(0, 15)), $urandom);
            end
            cycle($urandom_range(0, 4) == 0);
        end
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        drive(1, 0, 0, 4'h0, 10'd0, 0);
        cycle(0);

        // Reset right after a completed read.
        drive(0, 1, 1, 4'hF, 10'd5, 32'h5A5A1234); cycle(0);
        drive(0, 1, 0, 4'hF, 10'd5, 0);            cycle(0);
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        chk("pre_rst_rd", r0.data_r, 32'h5A5A1234);
        reset = 1'b0;
        #1;
        chk("midrst_data_r0", r0.data_r, 0);
        chk("midrst_data_r1", r1.data_r, 0);
        chk("midrst_cnt", cnt, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_data_r0", r0.data_r, 0);
        drive(0, 1, 0, 4'hF, 10'd1, 0);
        drive(1, 1, 0, 4'hF, 10'd2, 0);
        #1;
        chk("postrst_delay0", r0.delay, 0);
        chk("postrst_delay1", r1.delay, 1);
        cycle(0);
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        cycle(0);
        drive(1, 0, 0, 4'h0, 10'd0, 0);
        cycle(0);

        // Fixed priority: port 0 wins every cycle, port 1 starves.
        f0.en = 1'b1;
        f1.en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fp_delay0", f0.delay, 0);
            chk("fp_delay1", f1.delay, 1);
            chk("fp_mem_addr", fm.addr, 10'd3);
            @(posedge clk);
        end
        #1;
        f0.en = 1'b0;
        f1.en = 1'b0;
        chk("fp_cnt", fcnt, 8);

        // Counter saturation under long contention.
        drive(0, 1, 0, 4'hF, 10'd1, 0);
        drive(1, 1, 0, 4'hF, 10'd2, 0);
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_cnt", cnt, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", cnt, 16'hFFFF);
        drive(0, 0, 0, 4'h0, 10'd0, 0);
        drive(1, 0, 0, 4'h0, 10'd0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
